fifo_arbiter: RTL and testbench

FIFO_ARBITER -- requirements
Module: fifo_arbiter

---
 rtl/fifo_arbiter.sv | 143 ++++++++++++++
 tb/tb_fifo_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_arbiter.sv
// rtl/fifo_arbiter.sv - two-requester round-robin burst arbiter feeding one FIFO write port
//
// Purpose: grants one of two requesters at a time. The owner streams up to
// MAX_BURST words straight into the FIFO. Ownership then alternates whenever
// the other side is waiting.
//
// Parameters:
//   DATA_WIDTH  width of requester words and FIFO write data
//   MAX_BURST   words accepted per grant before re-arbitration (1..15)
//
// Ports:
//   clk            single clock, rising edge
//   reset          asynchronous, active-low reset
//   valid0/valid1  requester has a word available
//   data0/data1    requester words
//   ready0/ready1  word accepted this cycle (combinational, never both high)
//   full           FIFO full flag; stalls the current owner
//   wr             FIFO write strobe (ready0 | ready1)
//   w_data         FIFO write data; follows the owner, holds its last value when idle
//   grant          one-hot owner: 01 = requester 0, 10 = requester 1, 00 = idle
//
// Optional feature (macro FIFO_ARB_STATS_EN):
//   cnt0/cnt1      16-bit wrapping counts of accepted words per requester
module fifo_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid0,
  input  logic                  valid1,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  ready0,
  output logic                  ready1,
  input  logic                  full,
  output logic                  wr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [1:0]            grant
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]           cnt0,
  output logic [15:0]           cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t                state, state_nxt;
  logic                  last_owner, last_owner_nxt;
  logic [3:0]            burst, burst_nxt;
  logic [DATA_WIDTH-1:0] w_data_q;

  logic own;
  logic own_valid;
  logic other_valid;

  // Outputs depend only on the registered state plus the live inputs, so an
  // accepted word reaches the FIFO in the same cycle it is handed over.
  always_comb begin
    ready0 = (state == G0) & valid0 & ~full;
    ready1 = (state == G1) & valid1 & ~full;
    wr     = ready0 | ready1;
    grant  = state;
    case (state)
      G0:      w_data = data0;
      G1:      w_data = data1;
      default: w_data = w_data_q;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    burst_nxt      = burst;
    own            = (state == G1);
    own_valid      = 1'b0;
    other_valid    = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the requester that did not own the last burst wins.
        if (valid0 && valid1)
          state_nxt = last_owner ? G0 : G1;
        else if (valid0)
          state_nxt = G0;
        else if (valid1)
          state_nxt = G1;
      end
      G0, G1: begin
        own_valid   = own ? valid1 : valid0;
        other_valid = own ? valid0 : valid1;
        if (wr)
          burst_nxt = burst + 4'd1;
        // A burst closes on its last word or as soon as the owner has nothing
        // to offer; a full FIFO alone never closes it.
        if (!own_valid || (wr && burst == BURST_LAST)) begin
          last_owner_nxt = own;
          burst_nxt      = '0;
          if (other_valid)
            state_nxt = own ? G0 : G1;
          else if (own_valid)
            state_nxt = state;
          else
            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      burst      <= '0;
      w_data_q   <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      burst      <= burst_nxt;
      w_data_q   <= w_data;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      cnt0 <= cnt0 + 16'(ready0);
      cnt1 <= cnt1 + 16'(ready1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_arbiter.sv
// tb/tb_fifo_arbiter.sv - self-checking bench for fifo_arbiter
//
// Purpose: directed scenarios (single requester, tie, back-pressure, early
// release, reset mid-burst) checked every cycle against an ownership/burst
// model, plus literal expectations per scenario.
// Ports: none (top-level bench). Stats checks compile in with FIFO_ARB_STATS_EN.
module tb_fifo_arbiter;
  localparam int DW = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          valid0 = 1'b0, valid1 = 1'b0, full = 1'b0;
  logic [DW-1:0] data0 = '0, data1 = '0;
  logic          ready0, ready1, wr;
  logic [DW-1:0] w_data;
  logic [1:0]    grant;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]   cnt0, cnt1;
`endif

  fifo_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .valid0(valid0), .valid1(valid1),
    .data0(data0), .data1(data1),
    .ready0(ready0), .ready1(ready1),
    .full(full), .wr(wr), .w_data(w_data), .grant(grant)
`ifdef FIFO_ARB_STATS_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Requester word queues; the head is offered while the queue is non-empty.
  logic [DW-1:0] q0[$], q1[$];
  logic a0 = 1'b0, a1 = 1'b0;
  typedef struct { logic [1:0] g; logic [DW-1:0] d; } wr_t;
  wr_t wlog[$];
  int  stall_cnt = 0;

  // Model: who owns the port (-1 none), words taken this burst, last owner.
  int            m_owner = -1, m_count = 0, n_owner = -1, n_count = 0;
  bit            m_last = 1'b1, n_last = 1'b1;
  logic [DW-1:0] m_wdata = '0, n_wdata = '0;
  logic [15:0]   m_c0 = '0, m_c1 = '0, n_c0 = '0, n_c1 = '0;
  logic          e0, e1, vo, vx;
  logic [1:0]    eg;
  logic [DW-1:0] ewd;

  always @(negedge clk) begin
    if (!reset) begin
      e0 = 1'b0; e1 = 1'b0; eg = 2'b00; ewd = '0;
      n_owner = -1; n_count = 0; n_last = 1'b1; n_wdata = '0; n_c0 = '0; n_c1 = '0;
    end else begin
      e0  = (m_owner == 0) && valid0 && !full;
      e1  = (m_owner == 1) && valid1 && !full;
      eg  = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
      ewd = (m_owner == 0) ? data0 : (m_owner == 1) ? data1 : m_wdata;
      n_owner = m_owner; n_count = m_count; n_last = m_last; n_wdata = ewd;
      n_c0 = m_c0 + 16'(e0); n_c1 = m_c1 + 16'(e1);
      if (m_owner < 0) begin
        if (valid0 && valid1) n_owner = m_last ? 0 : 1;
        else if (valid0)      n_owner = 0;
        else if (valid1)      n_owner = 1;
      end else begin
        vo = (m_owner == 1) ? valid1 : valid0;
        vx = (m_owner == 1) ? valid0 : valid1;
        if (e0 || e1) n_count = m_count + 1;
        if (!vo || n_count == MB) begin
          n_last  = (m_owner == 1);
          n_count = 0;
          n_owner = vx ? 1 - m_owner : (vo ? m_owner : -1);
        end
      end
    end
    chk("ready0", ready0, e0);
    chk("ready1", ready1, e1);
    chk("wr", wr, e0 | e1);
    chk("grant", grant, eg);
    chk("w_data", w_data, ewd);
    chk("exclusive_ready", ready0 & ready1, 1'b0);
`ifdef FIFO_ARB_STATS_EN
    chk("cnt0", cnt0, m_c0);
    chk("cnt1", cnt1, m_c1);
`endif
    a0 = ready0;
    a1 = ready1;
    if (reset && wr) wlog.push_back('{g: grant, d: w_data});
    if (reset && grant == 2'b01 && !wr && full) stall_cnt++;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner <= -1; m_count <= 0; m_last <= 1'b1; m_wdata <= '0; m_c0 <= '0; m_c1 <= '0;
    end else begin
      m_owner <= n_owner; m_count <= n_count; m_last <= n_last; m_wdata <= n_wdata;
      m_c0 <= n_c0; m_c1 <= n_c1;
    end
  end

  task automatic drive();
    valid0 = (q0.size() > 0);
    valid1 = (q1.size() > 0);
    if (valid0) data0 = q0[0];
    if (valid1) data1 = q1[0];
  endtask

  task automatic step(input bit f);
    @(posedge clk); #1;
    if (a0 && q0.size() > 0) void'(q0.pop_front());
    if (a1 && q1.size() > 0) void'(q1.pop_front());
    full = f;
    drive();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    q0.delete(); q1.delete(); full = 1'b0; drive();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    wlog.delete();
    stall_cnt = 0;
  endtask

  initial begin
    // Single requester: one idle cycle, then six back-to-back writes in order.
    do_reset();
    for (int k = 1; k <= 6; k++) q0.push_back(DW'(k));
    drive();
    @(negedge clk); #1;
    chk("single_idle_grant", grant, 2'b00);
    chk("single_idle_wr", wr, 1'b0);
    chk("single_idle_wdata", w_data, 16'h0000);
    step(0);
    @(negedge clk); #1;
    chk("single_first_grant", grant, 2'b01);
    chk("single_first_wdata", w_data, 16'h0001);
    repeat (10) step(0);
    chk("single_count", wlog.size(), 6);
    for (int i = 0; i < wlog.size() && i < 6; i++)
      chk($sformatf("single_word%0d", i), {14'd0, wlog[i].g, wlog[i].d}, {14'd0, 2'b01, DW'(i + 1)});

    // Tie after reset: alternating bursts of four, requester 0 first.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      q0.push_back(16'h0100 + DW'(k));
      q1.push_back(16'h0200 + DW'(k));
    end
    drive();
    for (int c = 0; c < 80 && wlog.size() < 16; c++) step(0);
    q0.delete(); q1.delete(); drive();
    chk("tie_count", wlog.size(), 16);
    for (int i = 0; i < wlog.size() && i < 16; i++) begin
      logic [1:0]    g;
      logic [DW-1:0] d;
      g = ((i / 4) % 2 == 0) ? 2'b01 : 2'b10;
      d = ((g == 2'b01) ? 16'h0100 : 16'h0200) + DW'((i / 8) * 4 + i % 4);
      chk($sformatf("tie_word%0d", i), {14'd0, wlog[i].g, wlog[i].d}, {14'd0, g, d});
    end
`ifdef FIFO_ARB_STATS_EN
    @(negedge clk); #1;
    chk("stats_cnt0", cnt0, 16'd8);
    chk("stats_cnt1", cnt1, 16'd8);
`endif

    // Back-pressure: full for three cycles on the 2nd word of G0.
    do_reset();
    for (int k = 1; k <= 4; k++) q0.push_back(16'h0030 + DW'(k));
    q1.push_back(16'h0041);
    drive();
    step(0);
    step(1); step(1); step(1);
    repeat (8) step(0);
    chk("bp_stalls", stall_cnt, 3);
    chk("bp_count", wlog.size(), 5);
    for (int i = 0; i < wlog.size() && i < 4; i++)
      chk($sformatf("bp_word%0d", i), {14'd0, wlog[i].g, wlog[i].d}, {14'd0, 2'b01, 16'h0031 + DW'(i)});
    if (wlog.size() > 4)
      chk("bp_handover", {14'd0, wlog[4].g, wlog[4].d}, {14'd0, 2'b10, 16'h0041});

    // Early release: requester 0 runs dry after two words while 1 waits.
    do_reset();
    q0.push_back(16'h0051); q0.push_back(16'h0052);
    q1.push_back(16'h0061); q1.push_back(16'h0062);
    drive();
    step(0); step(0); step(0);
    @(negedge clk); #1;
    chk("early_drop_grant", grant, 2'b01);
    chk("early_drop_wr", wr, 1'b0);
    step(0);
    @(negedge clk); #1;
    chk("early_next_grant", grant, 2'b10);
    chk("early_next_wdata", w_data, 16'h0061);
    repeat (4) step(0);

    // Reset mid-burst: asynchronous clear, then requester 0 wins the tie.
    do_reset();
    q1.push_back(16'h0071); q1.push_back(16'h0072); q1.push_back(16'h0073);
    drive();
    step(0);
    step(0);
    #2 reset = 1'b0;
    #1;
    chk("async_grant", grant, 2'b00);
    chk("async_wr", wr, 1'b0);
    chk("async_ready1", ready1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    q0.push_back(16'h0081);
    drive();
    reset = 1'b1;
    wlog.delete();
    step(0);
    @(negedge clk); #1;
    chk("post_reset_grant", grant, 2'b01);
    chk("post_reset_wdata", w_data, 16'h0081);
    repeat (6) step(0);
    chk("post_reset_count", wlog.size(), 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
